// File: rtl/mux_rr_pkg.sv
// Shared constants and helpers for the round-robin arbiter family.
package mux_rr_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Advance an arbitration pointer past index i, wrapping modulo m (m need not be a power of 2).
  function automatic int unsigned next_ptr(input int unsigned i, input int unsigned m);
    return (i == m - 1) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational grant selection: fixed lowest-index priority or round-robin from ptr.
module rr_grant
  import mux_rr_pkg::*;
#(
  parameter  int unsigned M  = 8,
  localparam int unsigned SW = $clog2(M)
) (
  input  logic [M-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          mode,
  input  logic          en,
  output logic [M-1:0]  gnt,
  output logic [SW-1:0] g,
  output logic          any
);

  assign any = |req;

  always_comb begin
    int unsigned idx;
    logic        found;
    g     = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 0; off < M; off++) begin
      idx = (mode == MODE_RR) ? 32'(ptr) + off : off;
      // ptr < M and off < M, so one subtraction is enough to wrap
      if (idx >= M) idx = idx - M;
      if (!found && req[idx]) begin
        found = 1'b1;
        g     = SW'(idx);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (en && any) gnt[g] = 1'b1;
  end

endmodule

// File: rtl/mux_rr_8ch.sv
// Registered M-channel multiplexer with built-in fixed/round-robin arbitration and
// valid/ready flow control on both sides.
module mux_rr_8ch
  import mux_rr_pkg::*;
#(
  parameter  int unsigned N  = 4,
  parameter  int unsigned M  = 8,
  localparam int unsigned SW = $clog2(M)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [M*N-1:0] X,
  input  logic [M-1:0]   X_valid,
  output logic [M-1:0]   X_ready,
  input  logic           mode,
  output logic [N-1:0]   Z,
  output logic [SW-1:0]  S,
  output logic           Z_valid,
  input  logic           Z_ready
);

  logic [N-1:0]  r_z;
  logic [SW-1:0] r_s;
  logic          r_z_valid;
  logic [SW-1:0] r_ptr;

  logic          w_load;
  logic [M-1:0]  w_gnt;
  logic [SW-1:0] w_g;
  logic          w_any;
  logic [N-1:0]  w_data;

  assign w_load = ~r_z_valid | Z_ready;

  rr_grant #(
    .M (M)
  ) u_grant (
    .req  (X_valid),
    .ptr  (r_ptr),
    .mode (mode),
    .en   (w_load),
    .gnt  (w_gnt),
    .g    (w_g),
    .any  (w_any)
  );

  // Accept is masked during reset so no producer sees a transfer that will be dropped.
  assign X_ready = rst ? '0 : w_gnt;
  assign w_data  = X[w_g*N +: N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_z       <= '0;
      r_s       <= '0;
      r_z_valid <= 1'b0;
      r_ptr     <= '0;
    end else if (w_load) begin
      if (w_any) begin
        r_z       <= w_data;
        r_s       <= w_g;
        r_z_valid <= 1'b1;
        if (mode == MODE_RR) r_ptr <= SW'(next_ptr(32'(w_g), M));
      end else begin
        r_z_valid <= 1'b0;
      end
    end
  end

  assign Z       = r_z;
  assign S       = r_s;
  assign Z_valid = r_z_valid;

endmodule

// File: tb/tb_mux_rr_8ch.sv
// Scoreboard bench for mux_rr_8ch: an 8-channel x 4-bit instance and a 5-channel x 8-bit one.
module tb_mux_rr_8ch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] x;
  logic [7:0]  xv, xr;
  logic        mode, zv, zr;
  logic [3:0]  z;
  logic [2:0]  s;

  logic [39:0] x5;
  logic [4:0]  xv5, xr5;
  logic        mode5, zv5, zr5;
  logic [7:0]  z5;
  logic [2:0]  s5;

  int total = 0;
  int bad   = 0;

  int   m_ptr, m5_ptr;
  logic m_zv, m5_zv;

  typedef struct {logic [3:0] z; logic [2:0] s;} exp8_t;
  typedef struct {logic [7:0] z; logic [2:0] s;} exp5_t;
  exp8_t q8[$];
  exp5_t q5[$];
  exp8_t cur8;
  exp5_t cur5;

  mux_rr_8ch #(.N(4), .M(8)) u_dut (
    .clk(clk), .rst(rst), .X(x), .X_valid(xv), .X_ready(xr), .mode(mode),
    .Z(z), .S(s), .Z_valid(zv), .Z_ready(zr)
  );

  mux_rr_8ch #(.N(8), .M(5)) u_dut5 (
    .clk(clk), .rst(rst), .X(x5), .X_valid(xv5), .X_ready(xr5), .mode(mode5),
    .Z(z5), .S(s5), .Z_valid(zv5), .Z_ready(zr5)
  );

  function automatic int model_grant(input logic [7:0] v, input int m, input logic md,
                                     input int p);
    for (int i = 0; i < m; i++) begin
      int k;
      k = md ? (p + i) % m : i;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [7:0] exp_ready8();
    logic [7:0] r;
    int g;
    r = '0;
    g = model_grant(xv, 8, mode, m_ptr);
    if ((!m_zv || zr) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  function automatic logic [4:0] exp_ready5();
    logic [4:0] r;
    int g;
    r = '0;
    g = model_grant({3'b000, xv5}, 5, mode5, m5_ptr);
    if ((!m5_zv || zr5) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_zv = 1'b0; m5_ptr = 0; m5_zv = 1'b0;
    q8.delete(); q5.delete();
    cur8 = '{z: 4'h0, s: 3'd0};
    cur5 = '{z: 8'h00, s: 3'd0};
  endtask

  // Advance both models, push the words that should load, clock, then pop what is now on Z.
  task automatic step();
    int g;
    if (!m_zv || zr) begin
      g = model_grant(xv, 8, mode, m_ptr);
      if (g >= 0) begin
        q8.push_back('{z: x[g*4 +: 4], s: 3'(g)});
        m_zv = 1'b1;
        if (mode) m_ptr = (g == 7) ? 0 : g + 1;
      end else m_zv = 1'b0;
    end
    if (!m5_zv || zr5) begin
      g = model_grant({3'b000, xv5}, 5, mode5, m5_ptr);
      if (g >= 0) begin
        q5.push_back('{z: x5[g*8 +: 8], s: 3'(g)});
        m5_zv = 1'b1;
        if (mode5) m5_ptr = (g == 4) ? 0 : g + 1;
      end else m5_zv = 1'b0;
    end
    @(posedge clk);
    #1;
    if (q8.size() != 0) cur8 = q8.pop_front();
    if (q5.size() != 0) cur5 = q5.pop_front();
  endtask

  task automatic test_reset();
    rst = 1'b1; xv = 8'hFF; xv5 = 5'h1F; mode = 1'b0; mode5 = 1'b0; zr = 1'b0; zr5 = 1'b0;
    x = 32'h1234_567C; x5 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (xr !== 8'h00) begin bad++; $display("FAIL rst_xready got=%h want=00", xr); end
    total++; if ({zv, z, s} !== 8'h00) begin
      bad++; $display("FAIL rst_out got zv=%b z=%h s=%0d want 0/0/0", zv, z, s);
    end
    total++; if ({zv5, xr5} !== 6'h00) begin
      bad++; $display("FAIL rst_dut5 got zv=%b xr=%h want 0/00", zv5, xr5);
    end
    xv5 = 5'h00;
    rst = 1'b0;
    step();
    step();
    total++; if ({zv, z, s} !== {1'b1, 4'hC, 3'd0}) begin
      bad++; $display("FAIL pre_rst_word got zv=%b z=%h s=%0d want 1/c/0", zv, z, s);
    end
    #3 rst = 1'b1;
    #1;
    total++; if ({xr, zv, z, s} !== 16'h0000) begin
      bad++; $display("FAIL async_rst got xr=%h zv=%b z=%h s=%0d want all 0", xr, zv, z, s);
    end
    xv = 8'h00;
    #2 rst = 1'b0;
    model_reset();
    step();
    step();
    total++; if ({zv, zv5} !== 2'b00) begin
      bad++; $display("FAIL idle_after_rst got zv=%b zv5=%b want 0/0", zv, zv5);
    end
  endtask

  task automatic test_fixed();
    mode = 1'b0; zr = 1'b1; xv = 8'b1010_0100;
    x = $urandom; x[11:8] = 4'h2;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (xr !== 8'h04 || xr !== exp_ready8()) begin
        bad++; $display("FAIL fixed_xready[%0d] got=%h want=04", k, xr);
      end
      step();
      total++; if ({zv, z, s} !== {1'b1, cur8.z, cur8.s} || z !== 4'h2 || s !== 3'd2) begin
        bad++; $display("FAIL fixed_out[%0d] got zv=%b z=%h s=%0d want 1/2/2", k, zv, z, s);
      end
    end
  endtask

  task automatic test_rr_fair();
    mode = 1'b1; zr = 1'b1; xv = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      x = $urandom;
      #1;
      total++; if (xr !== exp_ready8()) begin
        bad++; $display("FAIL rr_xready[%0d] got=%h want=%h", k, xr, exp_ready8());
      end
      step();
      total++; if ({zv, z, s} !== {1'b1, cur8.z, cur8.s} || s !== 3'(k % 8)) begin
        bad++; $display("FAIL rr_fair[%0d] got zv=%b z=%h s=%0d want 1/%h/%0d",
                        k, zv, z, s, cur8.z, k % 8);
      end
    end
  endtask

  task automatic test_rr_skip();
    int exp_s[3] = '{0, 3, 0};
    mode = 1'b1; zr = 1'b1; xv = 8'h20; x = $urandom;
    step();
    total++; if (s !== 3'd5) begin bad++; $display("FAIL skip_setup got s=%0d want 5", s); end
    xv = 8'b0000_1001;
    for (int k = 0; k < 3; k++) begin
      x = $urandom;
      #1;
      total++; if (xr !== (8'h01 << exp_s[k])) begin
        bad++; $display("FAIL skip_xready[%0d] got=%h want=%h", k, xr, 8'h01 << exp_s[k]);
      end
      step();
      total++; if ({zv, z, s} !== {1'b1, cur8.z, 3'(exp_s[k])}) begin
        bad++; $display("FAIL skip_out[%0d] got z=%h s=%0d want %h/%0d",
                        k, z, s, cur8.z, exp_s[k]);
      end
    end
  endtask

  task automatic test_back_pressure();
    mode = 1'b0; zr = 1'b1; xv = 8'h20; x = $urandom; x[23:20] = 4'hA;
    step();
    total++; if ({zv, z, s} !== {1'b1, 4'hA, 3'd5}) begin
      bad++; $display("FAIL bp_load got zv=%b z=%h s=%0d want 1/a/5", zv, z, s);
    end
    zr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      xv = 8'($urandom) | 8'h01;
      x  = $urandom;
      mode = k[0];
      #1;
      total++; if (xr !== 8'h00) begin
        bad++; $display("FAIL bp_xready[%0d] got=%h want=00", k, xr);
      end
      step();
      total++; if ({zv, z, s} !== {1'b1, 4'hA, 3'd5}) begin
        bad++; $display("FAIL bp_hold[%0d] got zv=%b z=%h s=%0d want 1/a/5", k, zv, z, s);
      end
    end
    mode = 1'b0; zr = 1'b1; xv = 8'h02; x = $urandom; x[7:4] = 4'h7;
    #1;
    total++; if (xr !== 8'h02) begin bad++; $display("FAIL bp_release_xready got=%h want=02", xr); end
    step();
    total++; if ({zv, z, s} !== {1'b1, 4'h7, 3'd1} || z !== cur8.z) begin
      bad++; $display("FAIL bp_no_bubble got zv=%b z=%h s=%0d want 1/7/1", zv, z, s);
    end
    xv = 8'h00;
    step();
    total++; if (zv !== 1'b0) begin bad++; $display("FAIL drain got zv=%b want 0", zv); end
  endtask

  task automatic test_non_pow2();
    mode5 = 1'b1; zr5 = 1'b1; xv5 = 5'h1F;
    for (int k = 0; k < 12; k++) begin
      x5 = {8'($urandom), 32'($urandom)};
      #1;
      total++; if (xr5 !== exp_ready5()) begin
        bad++; $display("FAIL m5_xready[%0d] got=%h want=%h", k, xr5, exp_ready5());
      end
      step();
      total++; if ({zv5, z5, s5} !== {1'b1, cur5.z, cur5.s} || s5 !== 3'(k % 5)) begin
        bad++; $display("FAIL m5_out[%0d] got zv=%b z=%h s=%0d want 1/%h/%0d",
                        k, zv5, z5, s5, cur5.z, k % 5);
      end
    end
    xv5 = 5'h00;
    step();
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rr_fair();
    test_rr_skip();
    test_back_pressure();
    test_non_pow2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
